maze_move_ctrl: RTL and testbench

//  Sequences player moves in the maze game: edge-detects button presses, arbitrates

---
 rtl/maze_move_if.sv | 34 +++
 rtl/maze_move_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_maze_move_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/maze_move_if.sv
// Player-move bus: debounced button levels in, wall-map req/ack handshake,
// player position and status out. The controller takes the slave side.
interface maze_move_if #(
  parameter int X_W = 5,
  parameter int Y_W = 5
);
  logic           btn_u;
  logic           btn_d;
  logic           btn_l;
  logic           btn_r;
  logic           move_en;
  logic           map_req;
  logic [X_W-1:0] map_x;
  logic [Y_W-1:0] map_y;
  logic           map_ack;
  logic           map_wall;
  logic [X_W-1:0] xpos;
  logic [Y_W-1:0] ypos;
  logic           busy;
  logic           bump;
  logic           timeout;
  logic           win;
  logic [15:0]    move_count;

  modport slave (
    input  btn_u, btn_d, btn_l, btn_r, move_en, map_ack, map_wall,
    output map_req, map_x, map_y, xpos, ypos, busy, bump, timeout, win, move_count
  );

  modport master (
    output btn_u, btn_d, btn_l, btn_r, move_en, map_ack, map_wall,
    input  map_req, map_x, map_y, xpos, ypos, busy, bump, timeout, win, move_count
  );
endinterface

// File: rtl/maze_move_ctrl.sv
// Maze player move sequencer: button edge/priority, wall lookup handshake, commit.
// Optional hold-to-repeat moves when MOVE_REPEAT_EN is defined.
//
// state    | meaning
// S_IDLE   | waiting for a button press (move_en gates acceptance)
// S_LOOKUP | map_req held, waiting for map_ack or lookup timeout
// S_WIN    | goal reached, all buttons ignored until reset
module maze_move_ctrl #(
  parameter int X_W     = 5,
  parameter int Y_W     = 5,
  parameter int MAZE_W  = 32,
  parameter int MAZE_H  = 32,
  parameter int START_X = 1,
  parameter int START_Y = 1,
  parameter int GOAL_X  = 30,
  parameter int GOAL_Y  = 30,
  parameter int TIMEOUT = 15
`ifdef MOVE_REPEAT_EN
  , parameter int REPEAT_CYC = 12500000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  maze_move_if.slave bus
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WIN} state_t;
  typedef enum logic [1:0] {D_U = 2'd0, D_D = 2'd1, D_L = 2'd2, D_R = 2'd3} dir_t;

  state_t         state_q, state_d;
  logic [3:0]     btn_lvl, btn_q, press;
  logic [2:0]     press_res;
  logic           press_vld, move_vld, move_go, oob;
  dir_t           press_dir, move_dir;
  logic [X_W-1:0] tgt_x, map_x_q, map_x_d, xpos_q, xpos_d;
  logic [Y_W-1:0] tgt_y, map_y_q, map_y_d, ypos_q, ypos_d;
  logic           map_req_q, map_req_d, bump_q, bump_d;
  logic           timeout_q, timeout_d, win_q, win_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [TW-1:0]  wait_q, wait_d;

  // {valid, dir}; button vector is {u, d, l, r}, highest priority first
  function automatic logic [2:0] resolve(input logic [3:0] b);
    logic [2:0] r;
    r = 3'b000;
    if (b[3])      r = {1'b1, D_U};
    else if (b[2]) r = {1'b1, D_D};
    else if (b[1]) r = {1'b1, D_L};
    else if (b[0]) r = {1'b1, D_R};
    return r;
  endfunction

  assign btn_lvl   = {bus.btn_u, bus.btn_d, bus.btn_l, bus.btn_r};
  assign press     = btn_lvl & ~btn_q;
  assign press_res = resolve(press);
  assign press_vld = press_res[2];
  assign press_dir = dir_t'(press_res[1:0]);
  assign move_go   = (state_q == S_IDLE) && bus.move_en && move_vld;

`ifdef MOVE_REPEAT_EN
  localparam int RW = (REPEAT_CYC > 2) ? $clog2(REPEAT_CYC) : 1;

  logic [2:0]    held_res;
  logic          held_vld, rep_fire, rep_act_q, rep_act_d;
  dir_t          held_dir, rep_dir_q, rep_dir_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;

  assign held_res = resolve(btn_lvl);
  assign held_vld = held_res[2];
  assign held_dir = dir_t'(held_res[1:0]);
  assign rep_fire = rep_act_q && held_vld && (held_dir == rep_dir_q) && (rep_cnt_q == '0);
  assign move_vld = press_vld | rep_fire;
  assign move_dir = press_vld ? press_dir : held_dir;

  // Down-counter reloads on every issued move and on any change of held direction
  always_comb begin
    rep_act_d = rep_act_q;
    rep_dir_d = rep_dir_q;
    rep_cnt_d = rep_cnt_q;
    if (!held_vld) begin
      rep_act_d = 1'b0;
    end else if (move_go || !rep_act_q || (held_dir != rep_dir_q)) begin
      rep_act_d = 1'b1;
      rep_dir_d = held_dir;
      rep_cnt_d = RW'(REPEAT_CYC - 1);
    end else if (rep_cnt_q != '0) begin
      rep_cnt_d = rep_cnt_q - RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_act_q <= 1'b0;
      rep_dir_q <= D_U;
      rep_cnt_q <= '0;
    end else begin
      rep_act_q <= rep_act_d;
      rep_dir_q <= rep_dir_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end
`else
  assign move_vld = press_vld;
  assign move_dir = press_dir;
`endif

  always_comb begin
    tgt_x = xpos_q;
    tgt_y = ypos_q;
    oob   = 1'b0;
    case (move_dir)
      D_U: begin oob = (ypos_q == '0);                  tgt_y = ypos_q - Y_W'(1); end
      D_D: begin oob = (ypos_q == Y_W'(MAZE_H - 1));    tgt_y = ypos_q + Y_W'(1); end
      D_L: begin oob = (xpos_q == '0);                  tgt_x = xpos_q - X_W'(1); end
      D_R: begin oob = (xpos_q == X_W'(MAZE_W - 1));    tgt_x = xpos_q + X_W'(1); end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    map_req_d = map_req_q;
    map_x_d   = map_x_q;
    map_y_d   = map_y_q;
    xpos_d    = xpos_q;
    ypos_d    = ypos_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    win_d     = win_q;
    bump_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (move_go) begin
          if (oob) begin
            bump_d = 1'b1;
          end else begin
            map_x_d   = tgt_x;
            map_y_d   = tgt_y;
            map_req_d = 1'b1;
            wait_d    = TW'(TIMEOUT - 1);
            state_d   = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: begin
        if (bus.map_ack) begin
          map_req_d = 1'b0;
          if (bus.map_wall) begin
            bump_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            xpos_d = map_x_q;
            ypos_d = map_y_q;
            cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            if ((map_x_q == X_W'(GOAL_X)) && (map_y_q == Y_W'(GOAL_Y))) begin
              win_d   = 1'b1;
              state_d = S_WIN;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else if (wait_q == '0) begin
          timeout_d = 1'b1;
          map_req_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          wait_d = wait_q - TW'(1);
        end
      end
      S_WIN: begin
        map_req_d = 1'b0;
      end
      default: begin
        map_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      btn_q     <= '0;
      map_req_q <= 1'b0;
      map_x_q   <= '0;
      map_y_q   <= '0;
      xpos_q    <= X_W'(START_X);
      ypos_q    <= Y_W'(START_Y);
      cnt_q     <= '0;
      wait_q    <= '0;
      win_q     <= 1'b0;
      bump_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      btn_q     <= btn_lvl;
      map_req_q <= map_req_d;
      map_x_q   <= map_x_d;
      map_y_q   <= map_y_d;
      xpos_q    <= xpos_d;
      ypos_q    <= ypos_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      win_q     <= win_d;
      bump_q    <= bump_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.map_req    = map_req_q;
  assign bus.map_x      = map_x_q;
  assign bus.map_y      = map_y_q;
  assign bus.xpos       = xpos_q;
  assign bus.ypos       = ypos_q;
  assign bus.busy       = (state_q == S_LOOKUP);
  assign bus.bump       = bump_q;
  assign bus.timeout    = timeout_q;
  assign bus.win        = win_q;
  assign bus.move_count = cnt_q;

endmodule

// File: tb/tb_maze_move_ctrl.sv
// Directed bench for maze_move_ctrl: move vector table plus timeout, move_en,
// mid-lookup reset and goal sequences (second instance with goal at (2,1)).
module tb_maze_move_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  maze_move_if #(.X_W(5), .Y_W(5)) bus ();
  maze_move_if #(.X_W(5), .Y_W(5)) gbus ();

  maze_move_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  maze_move_ctrl #(.GOAL_X(2), .GOAL_Y(1)) dut_g (.clk(clk), .reset(reset), .bus(gbus));

  typedef struct {
    logic [3:0] btn;   // {u, d, l, r}
    logic       look;
    int         dly;
    logic       wall;
    logic [4:0] tx, ty, ex, ey;
    logic       ebump;
    int         ecnt;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] b);
    {bus.btn_u, bus.btn_d, bus.btn_l, bus.btn_r} = b;
  endtask

  task automatic ack(input logic wall);
    bus.map_ack  = 1'b1;
    bus.map_wall = wall;
    tick();
    bus.map_ack  = 1'b0;
    bus.map_wall = 1'b0;
  endtask

  initial begin
    vec_t v;
    // btn       look  dly wall tx  ty  ex  ey  bump cnt
    vecs[0] = '{4'b1000, 1'b1, 2, 1'b1, 5'd1, 5'd0, 5'd1, 5'd1, 1'b1, 0};
    vecs[1] = '{4'b0001, 1'b1, 3, 1'b0, 5'd2, 5'd1, 5'd2, 5'd1, 1'b0, 1};
    vecs[2] = '{4'b0010, 1'b1, 1, 1'b0, 5'd1, 5'd1, 5'd1, 5'd1, 1'b0, 2};
    vecs[3] = '{4'b0010, 1'b1, 0, 1'b0, 5'd0, 5'd1, 5'd0, 5'd1, 1'b0, 3};
    vecs[4] = '{4'b0010, 1'b0, 0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd1, 1'b1, 3};
    vecs[5] = '{4'b1001, 1'b1, 1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 4};
    vecs[6] = '{4'b1000, 1'b0, 0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 4};
    vecs[7] = '{4'b0110, 1'b1, 2, 1'b1, 5'd0, 5'd1, 5'd0, 5'd0, 1'b1, 4};
    vecs[8] = '{4'b0011, 1'b0, 0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 4};
    vecs[9] = '{4'b0100, 1'b1, 0, 1'b0, 5'd0, 5'd1, 5'd0, 5'd1, 1'b0, 5};

    set_btn(4'b0000);
    bus.move_en  = 1'b1;
    bus.map_ack  = 1'b0;
    bus.map_wall = 1'b0;
    {gbus.btn_u, gbus.btn_d, gbus.btn_l, gbus.btn_r} = 4'b0000;
    gbus.move_en  = 1'b1;
    gbus.map_ack  = 1'b0;
    gbus.map_wall = 1'b0;

    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_xpos", bus.xpos, 1);
    chk("rst_ypos", bus.ypos, 1);
    chk("rst_req", bus.map_req, 0);
    chk("rst_win", bus.win, 0);
    chk("rst_bump", bus.bump, 0);
    chk("rst_count", bus.move_count, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_timeout", bus.timeout, 0);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      set_btn(v.btn);
      tick();
      set_btn(4'b0000);
      if (v.look) begin
        chk($sformatf("v%0d_req", i), bus.map_req, 1);
        chk($sformatf("v%0d_map_x", i), bus.map_x, v.tx);
        chk($sformatf("v%0d_map_y", i), bus.map_y, v.ty);
        for (int k = 0; k < v.dly; k++) tick();
        chk($sformatf("v%0d_req_held", i), bus.map_req, 1);
        chk($sformatf("v%0d_busy", i), bus.busy, 1);
        chk($sformatf("v%0d_map_xy_held", i), {bus.map_x, bus.map_y}, {v.tx, v.ty});
        ack(v.wall);
      end
      chk($sformatf("v%0d_req_low", i), bus.map_req, 0);
      chk($sformatf("v%0d_xpos", i), bus.xpos, v.ex);
      chk($sformatf("v%0d_ypos", i), bus.ypos, v.ey);
      chk($sformatf("v%0d_bump", i), bus.bump, v.ebump);
      chk($sformatf("v%0d_count", i), bus.move_count, v.ecnt);
      chk($sformatf("v%0d_busy_low", i), bus.busy, 0);
      tick();
      chk($sformatf("v%0d_bump_pulse", i), bus.bump, 0);
    end

    // Lookup timeout from (0,1): map_req stays up for 15 cycles, then drops
    set_btn(4'b0001);
    tick();
    set_btn(4'b0000);
    chk("to_req_first", bus.map_req, 1);
    for (int k = 1; k < 15; k++) begin
      tick();
      chk($sformatf("to_req_c%0d", k), bus.map_req, 1);
    end
    tick();
    chk("to_pulse", bus.timeout, 1);
    chk("to_req_drop", bus.map_req, 0);
    chk("to_busy", bus.busy, 0);
    chk("to_xpos", bus.xpos, 0);
    tick();
    chk("to_pulse_end", bus.timeout, 0);
    set_btn(4'b0001);
    tick();
    set_btn(4'b0000);
    chk("to_next_req", bus.map_req, 1);
    chk("to_next_map_x", bus.map_x, 1);
    ack(1'b0);
    chk("to_next_xpos", bus.xpos, 1);
    chk("to_next_count", bus.move_count, 6);

    // move_en gating, no queueing, and move_en drop not aborting a lookup
    bus.move_en = 1'b0;
    set_btn(4'b0100);
    tick();
    set_btn(4'b0000);
    chk("en0_req", bus.map_req, 0);
    chk("en0_bump", bus.bump, 0);
    bus.move_en = 1'b1;
    tick();
    chk("en0_not_queued", bus.map_req, 0);
    set_btn(4'b0001);
    tick();
    set_btn(4'b0000);
    chk("en_req", bus.map_req, 1);
    chk("en_map_x", bus.map_x, 2);
    bus.move_en = 1'b0;
    set_btn(4'b1000);
    tick();
    set_btn(4'b0000);
    tick();
    chk("en_drop_req", bus.map_req, 1);
    chk("en_drop_map_y", bus.map_y, 1);
    ack(1'b0);
    chk("en_drop_xpos", bus.xpos, 2);
    chk("en_drop_ypos", bus.ypos, 1);
    chk("en_drop_count", bus.move_count, 7);
    bus.move_en = 1'b1;
    tick();
    chk("busy_press_dropped", bus.map_req, 0);

    // Reset during LOOKUP, then a late ack must be ignored
    set_btn(4'b0001);
    tick();
    set_btn(4'b0000);
    chk("mr_req", bus.map_req, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_req_drop", bus.map_req, 0);
    chk("mr_xpos", bus.xpos, 1);
    chk("mr_count", bus.move_count, 0);
    ack(1'b0);
    tick();
    chk("mr_late_xpos", bus.xpos, 1);
    chk("mr_late_count", bus.move_count, 0);
    chk("mr_late_req", bus.map_req, 0);

    // Goal at (2,1): one step right wins, later presses are ignored
    gbus.btn_r = 1'b1;
    tick();
    gbus.btn_r = 1'b0;
    chk("g_req", gbus.map_req, 1);
    chk("g_map_x", gbus.map_x, 2);
    gbus.map_ack = 1'b1;
    tick();
    gbus.map_ack = 1'b0;
    chk("g_win", gbus.win, 1);
    chk("g_xpos", gbus.xpos, 2);
    chk("g_req_low", gbus.map_req, 0);
    gbus.btn_l = 1'b1;
    tick();
    gbus.btn_l = 1'b0;
    chk("g_press_req", gbus.map_req, 0);
    tick();
    chk("g_press_req2", gbus.map_req, 0);
    chk("g_win_sticky", gbus.win, 1);
    chk("g_press_xpos", gbus.xpos, 2);
    chk("g_press_bump", gbus.bump, 0);
    chk("main_no_win", bus.win, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
